// File: rtl/usb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : usb_fifo_reader
// Description : RX-direction FX2 packet reader (usbclk domain).
//               Picks a channel whose RX buffer holds a complete 512-byte
//               packet (round-robin over NUM_CHAN data channels + 1 control
//               channel). It pulls the packet as PKT_WORDS 32-bit words from
//               the channel RAM and presents it to the FX2 as 16-bit words,
//               low half first. One word is consumed per usbclk edge with
//               RD_fx2 high.
// Ports       : usbclk          - clock
//               bus_reset       - asynchronous active-high reset
//               RD_fx2          - FX2 read strobe (consumes usbdata)
//               usbdata         - registered 16-bit word presented to FX2
//               pkt_waiting     - a packet is staged and readable
//               have_pkt_rdy    - per-channel complete-packet flags
//               RD_channel      - one-hot read pulse to channel RAM
//               ram_data        - channel RAM read data
//               RD_done_channel - one-hot pulse, packet fully delivered
// Revision    : 1.0 - initial release
// ============================================================================
module usb_fifo_reader #(
    parameter int NUM_CHAN   = 2,
    parameter int FIFO_WIDTH = 32,
    parameter int PKT_WORDS  = 128
) (
    input  logic                  usbclk,
    input  logic                  bus_reset,
    input  logic                  RD_fx2,
    output logic [15:0]           usbdata,
    output logic                  pkt_waiting,
    input  logic [NUM_CHAN:0]     have_pkt_rdy,
    output logic [NUM_CHAN:0]     RD_channel,
    input  logic [FIFO_WIDTH-1:0] ram_data,
    output logic [NUM_CHAN:0]     RD_done_channel
);

    localparam int NC = NUM_CHAN + 1;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_LOAD   = 2'd2;
    localparam logic [1:0] c_STREAM = 2'd3;

    localparam logic [7:0]    c_PKT_WORDS = 8'(PKT_WORDS);
    localparam logic [NC-1:0] c_ONE       = NC'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         r_chan;
    logic [CW-1:0]         r_last;
    logic [FIFO_WIDTH-1:0] r_hold;
    logic [7:0]            r_loaded;
    logic                  r_half;

    logic [CW-1:0]         w_chan_nxt;
    logic [CW-1:0]         w_last_nxt;
    logic [FIFO_WIDTH-1:0] w_hold_nxt;
    logic [7:0]            w_loaded_nxt;
    logic                  w_half_nxt;
    logic [15:0]           w_usbdata_nxt;
    logic                  w_pkt_waiting_nxt;
    logic [NC-1:0]         w_rd_channel_nxt;
    logic [NC-1:0]         w_rd_done_nxt;

    logic                  w_found;
    logic [CW-1:0]         w_pick;
    logic [CW:0]           w_idx;
    logic [NC-1:0]         w_chan_oh;
    logic                  w_last_read;

    // ------------------------------------------------------------------
    // Round-robin scan: start one past the last served channel and wrap.
    // w_idx carries one extra bit so last+1+i never overflows before the
    // modulo correction.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NC; i++) begin
            w_idx = {1'b0, r_last} + (CW+1)'(i + 1);
            if (w_idx >= (CW+1)'(NC)) begin
                w_idx = w_idx - (CW+1)'(NC);
            end
            if (!w_found && have_pkt_rdy[w_idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[CW-1:0];
            end
        end
    end

    assign w_chan_oh   = c_ONE << r_chan;
    assign w_last_read = RD_fx2 && r_half && (r_loaded == c_PKT_WORDS);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge usbclk or posedge bus_reset) begin
        if (bus_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_found) w_state_nxt = c_FETCH;
            c_FETCH:  w_state_nxt = c_LOAD;
            c_LOAD:   w_state_nxt = c_STREAM;
            c_STREAM: if (w_last_read) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. RD_channel and RD_done_channel are
    // single-cycle pulses, so they default to zero every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_chan_nxt        = r_chan;
        w_last_nxt        = r_last;
        w_hold_nxt        = r_hold;
        w_loaded_nxt      = r_loaded;
        w_half_nxt        = r_half;
        w_usbdata_nxt     = usbdata;
        w_pkt_waiting_nxt = pkt_waiting;
        w_rd_channel_nxt  = '0;
        w_rd_done_nxt     = '0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_chan_nxt       = w_pick;
                    w_rd_channel_nxt = c_ONE << w_pick;
                end
            end
            c_LOAD: begin
                // First word arrives; prefetch the second one right away so
                // it is ready by the time the FX2 asks for it.
                w_hold_nxt        = ram_data;
                w_usbdata_nxt     = ram_data[15:0];
                w_loaded_nxt      = 8'd1;
                w_half_nxt        = 1'b0;
                w_pkt_waiting_nxt = 1'b1;
                w_rd_channel_nxt  = w_chan_oh;
            end
            c_STREAM: begin
                if (RD_fx2) begin
                    if (!r_half) begin
                        w_usbdata_nxt = r_hold[31:16];
                        w_half_nxt    = 1'b1;
                    end else if (r_loaded < c_PKT_WORDS) begin
                        w_hold_nxt    = ram_data;
                        w_usbdata_nxt = ram_data[15:0];
                        w_loaded_nxt  = r_loaded + 8'd1;
                        w_half_nxt    = 1'b0;
                        if ((r_loaded + 8'd1) < c_PKT_WORDS) begin
                            w_rd_channel_nxt = w_chan_oh;
                        end
                    end else begin
                        // Final half-word consumed; usbdata keeps its value.
                        w_pkt_waiting_nxt = 1'b0;
                        w_rd_done_nxt     = w_chan_oh;
                        w_last_nxt        = r_chan;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge usbclk or posedge bus_reset) begin
        if (bus_reset) begin
            r_chan          <= '0;
            r_last          <= CW'(NUM_CHAN);
            r_hold          <= '0;
            r_loaded        <= '0;
            r_half          <= 1'b0;
            usbdata         <= '0;
            pkt_waiting     <= 1'b0;
            RD_channel      <= '0;
            RD_done_channel <= '0;
        end else begin
            r_chan          <= w_chan_nxt;
            r_last          <= w_last_nxt;
            r_hold          <= w_hold_nxt;
            r_loaded        <= w_loaded_nxt;
            r_half          <= w_half_nxt;
            usbdata         <= w_usbdata_nxt;
            pkt_waiting     <= w_pkt_waiting_nxt;
            RD_channel      <= w_rd_channel_nxt;
            RD_done_channel <= w_rd_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_fifo_reader
// Description : Self-checking bench for usb_fifo_reader. A behavioural
//               channel RAM returns word k of channel c as
//               {c*0x1000 + 2k+1, c*0x1000 + 2k}, so the expected usbdata
//               stream of a packet on channel c is c*0x1000 + 0..255.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_fifo_reader;

    localparam int NCH = 3;

    logic        usbclk = 1'b0;
    logic        bus_reset = 1'b1;
    logic        RD_fx2 = 1'b0;
    logic [15:0] usbdata;
    logic        pkt_waiting;
    logic [2:0]  have_pkt_rdy = 3'b000;
    logic [2:0]  RD_channel;
    logic [31:0] ram_data = 32'h0;
    logic [2:0]  RD_done_channel;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt [NCH];
    int ptr    [NCH];
    int done_cnt = 0;
    int oh_err   = 0;

    typedef struct {
        logic [2:0] rdy;
        bit         gaps;
        int         drop_after;
        int         extra;
        int         exp_chan;
    } vec_t;

    usb_fifo_reader #(.NUM_CHAN(2), .FIFO_WIDTH(32), .PKT_WORDS(128)) dut (
        .usbclk          (usbclk),
        .bus_reset       (bus_reset),
        .RD_fx2          (RD_fx2),
        .usbdata         (usbdata),
        .pkt_waiting     (pkt_waiting),
        .have_pkt_rdy    (have_pkt_rdy),
        .RD_channel      (RD_channel),
        .ram_data        (ram_data),
        .RD_done_channel (RD_done_channel)
    );

    always #5 usbclk = ~usbclk;

    function automatic logic [31:0] ram_word(input int c, input int k);
        return {16'((c << 12) + 2*k + 1), 16'((c << 12) + 2*k)};
    endfunction

    // Channel RAM model: data valid the cycle after the edge sampling RD.
    always @(posedge usbclk or posedge bus_reset) begin
        if (bus_reset) begin
            for (int c = 0; c < NCH; c++) ptr[c] <= 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (RD_channel[c]) begin
                    ram_data <= ram_word(c, ptr[c]);
                    ptr[c]   <= ptr[c] + 1;
                end
                if (RD_done_channel[c]) ptr[c] <= 0;
            end
        end
    end

    // Pulse counters and one-hot monitor, sampled just after each edge.
    initial for (int c = 0; c < NCH; c++) rd_cnt[c] = 0;
    always @(posedge usbclk) begin
        #1;
        for (int c = 0; c < NCH; c++) if (RD_channel[c]) rd_cnt[c]++;
        if (RD_done_channel != 3'b000) done_cnt++;
        if (!$onehot0(RD_channel) || !$onehot0(RD_done_channel) ||
            (RD_channel != 3'b000 && RD_done_channel != 3'b000 &&
             RD_channel != RD_done_channel))
            oh_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Serve one packet. Called at a negedge with the DUT idle.
    task automatic run_packet(input vec_t v);
        int base, start_cnt, lat, j, bad, iter, done_before;
        base      = v.exp_chan << 12;
        start_cnt = rd_cnt[v.exp_chan];
        have_pkt_rdy = v.rdy;
        RD_fx2 = 1'b0;
        lat = 0;
        while (!pkt_waiting && lat < 20) begin
            @(negedge usbclk);
            lat++;
        end
        check($sformatf("latency ch%0d", v.exp_chan), lat, 3);
        bad = 0; j = 0; iter = 0;
        while (j < 256 && iter < 4000) begin
            if (usbdata !== 16'(base + j) || !pkt_waiting) bad++;
            if (v.drop_after > 0 && j == v.drop_after) have_pkt_rdy = 3'b000;
            if (v.gaps && $urandom_range(0, 2) == 0) RD_fx2 = 1'b0;
            else begin
                RD_fx2 = 1'b1;
                j++;
            end
            @(negedge usbclk);
            iter++;
        end
        check($sformatf("reads done ch%0d", v.exp_chan), j, 256);
        check($sformatf("data seq errors ch%0d", v.exp_chan), bad, 0);
        check($sformatf("rd_done ch%0d", v.exp_chan), RD_done_channel, 32'(1) << v.exp_chan);
        check($sformatf("pkt_waiting low ch%0d", v.exp_chan), pkt_waiting, 0);
        check($sformatf("usbdata hold ch%0d", v.exp_chan), usbdata, 16'(base + 255));
        check($sformatf("rd pulses ch%0d", v.exp_chan), rd_cnt[v.exp_chan] - start_cnt, 128);
        have_pkt_rdy = 3'b000;
        if (v.extra > 0) begin
            done_before = done_cnt;
            repeat (v.extra) @(negedge usbclk);
            check("overread pkt_waiting", pkt_waiting, 0);
            check("overread usbdata", usbdata, 16'(base + 255));
            check("overread rd pulses", rd_cnt[v.exp_chan] - start_cnt, 128);
            check("overread extra done", done_cnt - done_before, 0);
        end
        RD_fx2 = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{rdy: 3'b111, gaps: 1'b0, drop_after: 0,  extra: 0,  exp_chan: 0};
        vecs[1] = '{rdy: 3'b111, gaps: 1'b0, drop_after: 0,  extra: 0,  exp_chan: 1};
        vecs[2] = '{rdy: 3'b111, gaps: 1'b0, drop_after: 0,  extra: 0,  exp_chan: 2};
        vecs[3] = '{rdy: 3'b111, gaps: 1'b0, drop_after: 0,  extra: 0,  exp_chan: 0};
        vecs[4] = '{rdy: 3'b001, gaps: 1'b1, drop_after: 0,  extra: 0,  exp_chan: 0};
        vecs[5] = '{rdy: 3'b100, gaps: 1'b0, drop_after: 10, extra: 0,  exp_chan: 2};
        vecs[6] = '{rdy: 3'b001, gaps: 1'b0, drop_after: 0,  extra: 44, exp_chan: 0};

        // Reset state
        repeat (3) @(negedge usbclk);
        check("reset outputs", {usbdata, pkt_waiting, RD_channel, RD_done_channel}, 0);
        bus_reset = 1'b0;
        @(negedge usbclk);
        check("idle no request", {pkt_waiting, RD_channel}, 0);

        for (int i = 0; i < 7; i++) run_packet(vecs[i]);

        // Asynchronous reset in the middle of a packet
        have_pkt_rdy = 3'b001;
        for (int i = 0; i < 20 && !pkt_waiting; i++) @(negedge usbclk);
        repeat (100) begin
            RD_fx2 = 1'b1;
            @(negedge usbclk);
        end
        RD_fx2 = 1'b0;
        check("pre-reset usbdata", usbdata, 16'd100);
        #2 bus_reset = 1'b1;
        #1 check("async reset outputs", {usbdata, pkt_waiting, RD_channel, RD_done_channel}, 0);
        have_pkt_rdy = 3'b000;
        @(negedge usbclk);
        bus_reset = 1'b0;
        run_packet('{rdy: 3'b010, gaps: 1'b0, drop_after: 0, extra: 0, exp_chan: 1});

        repeat (3) @(negedge usbclk);
        check("one-hot violations", oh_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_fifo_reader.md
Name: usb_fifo_reader

Overview:
- RX-direction counterpart of the TX USB writer path, in the usbclk domain.
- Picks a channel whose RX packet buffer holds a complete 512-byte packet, using round-robin over NUM_CHAN+1 channels.
- Pulls that packet as 128 32-bit words from the channel RAM.
- Serializes the words to the FX2 as 256 16-bit words under the FX2 read strobe, low half first, matching the writer's {second, first} packing.
- Channel NUM_CHAN is the control/command channel.

Parameters:
NUM_CHAN, 2, number of data channels; NUM_CHAN+1 channels in total including control.
FIFO_WIDTH, 32, RAM word width; fixed at 32.
PKT_WORDS, 128, 32-bit words per packet (512 bytes).

Ports:
usbclk  in  1  single clock
bus_reset  in  1  asynchronous, active-high reset
RD_fx2  in  1  FX2 read strobe; each cycle high at a rising edge consumes the current usbdata word
usbdata  out  16  current word presented to FX2 (registered)
pkt_waiting  out  1  a packet is staged and readable by FX2
have_pkt_rdy  in  NUM_CHAN+1  per-channel "complete packet available" flag
RD_channel  out  NUM_CHAN+1  one-hot, one-cycle read pulse to the selected channel RAM
ram_data  in  32  channel RAM output
RD_done_channel  out  NUM_CHAN+1  one-cycle pulse: packet fully delivered, buffer may release it

Behaviour:
- Upstream RAM contract: ram_data is valid from the cycle after the edge that samples RD_channel high, and holds until the next RD pulse.
- Reset (async, any time including mid-packet):
  - usbdata=0, pkt_waiting=0, RD_channel=0, RD_done_channel=0.
  - state=IDLE, half=0, word counters=0, rr pointer last=NUM_CHAN (so channel 0 has first priority).
- States: IDLE, FETCH, LOAD, STREAM.
- IDLE:
  - Scan have_pkt_rdy starting at (last+1) mod (NUM_CHAN+1); the first set bit wins.
  - On a hit: latch chan, set RD_channel[chan]=1, go to FETCH.
  - No hit: stay in IDLE.
- FETCH: clear RD_channel, go to LOAD.
- LOAD:
  - hold<=ram_data; usbdata<=ram_data[15:0]; loaded=1; half=0.
  - pkt_waiting<=1.
  - Issue prefetch RD_channel[chan]=1 for one cycle.
  - Go to STREAM.
  - pkt_waiting therefore rises on the 3rd edge after IDLE sees the request.
- STREAM, RD_fx2 high, half=0: usbdata<=hold[31:16]; half<=1.
- STREAM, RD_fx2 high, half=1, loaded<PKT_WORDS:
  - hold<=ram_data; usbdata<=ram_data[15:0]; loaded++; half<=0.
  - Issue RD_channel[chan] pulse if the new loaded<PKT_WORDS.
- Prefetch timing:
  - The prefetch pulse is issued on every word load, so ram_data is always valid by the second read after a load.
  - FX2 may therefore read on every consecutive cycle with no stall.
  - Total RD_channel pulses per packet = 128.
- STREAM, RD_fx2 high, half=1, loaded==PKT_WORDS (256th read):
  - pkt_waiting<=0; RD_done_channel[chan]<=1 for one cycle; last<=chan; state IDLE.
  - usbdata holds its last value.
- RD_fx2 low: nothing changes; the word stays presented.
- RD_fx2 while not in STREAM (IDLE, FETCH, LOAD, or after the 256th read): ignored, no state change. This covers the FX2 over-read bug.
- have_pkt_rdy[chan] dropping mid-packet is ignored; the packet completes.
- have_pkt_rdy[chan] still set after RD_done: that channel is eligible again only after the other ready channels in round-robin order.
- RD_channel and RD_done_channel are one-hot or zero at all times and never both nonzero for different channels in the same cycle.
- Counter widths:
  - loaded is 8 bits, range 1..128, no wrap.
  - half is 1 bit.

Test Plan:
- Reset then have_pkt_rdy=3'b001, RAM word k = {16'h(2k+1), 16'h(2k)}, RD_fx2 held high → usbdata sequence 0000,0001,...,00FF across 256 consecutive reads, no gaps; exactly 128 RD_channel[0] pulses; RD_done_channel[0] one cycle after the 256th read; pkt_waiting low the same edge.
- have_pkt_rdy=3'b111 continuously → packets served in channel order 0,1,2,0; each RD_done one-hot matches the served channel.
- RD_fx2 toggling 1,0,0,1 with random gaps → same 256-word sequence, no duplicates or drops; usbdata stable during gaps.
- 300 RD_fx2 cycles on one packet → only 256 consumed; reads 257–300 change nothing; no extra RD_channel pulses.
- Assert bus_reset at read 100 → all outputs 0 immediately (async); after release with have_pkt_rdy=3'b010, channel 1 is served with a fresh sequence starting at its word 0.
- have_pkt_rdy=3'b100 (control channel), drop it after 10 reads → packet still completes 256 reads; RD_done_channel=3'b100.
